// File: rtl/ascii_loader_if.sv
// ascii_loader_if
//   Byte-download bus between hps_io and ascii_loader.
//
//   Handshake: ioctl_wr is a one-cycle strobe qualified by ioctl_download;
//   ioctl_data is valid only in that cycle. There is no ready signal.
//   ioctl_wait is advisory backpressure: the producer must stop strobing
//   while it is high. The loader raises it early enough to absorb the
//   producer's one-cycle reaction lag. A strobe that still arrives on a
//   full FIFO is dropped and flagged.
//
//   Signals:
//     ioctl_download  high while an HPS transfer is active
//     ioctl_wr        write strobe
//     ioctl_data      downloaded byte
//     ioctl_wait      backpressure from loader to hps_io
interface ascii_loader_if;
    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_data;
    logic       ioctl_wait;

    modport master (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_data,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_wr,
        input  ioctl_data,
        output ioctl_wait
    );
endinterface

// File: rtl/ascii_loader.sv
// ascii_loader
//   Buffers the "Load Ascii" byte stream from hps_io in a FIFO and replays
//   it as 8N1 serial on txd, for the UK101 ACIA receive line. Carriage
//   returns are followed by an optional idle gap so BASIC can digest each
//   line. Optional LF stripping happens at the FIFO write side.
//
//   Optional build macro: ASCII_UPCASE_EN maps a-z to A-Z at FIFO write.
//   LF filtering always looks at the raw byte, before the case map.
//
//   Ports:
//     clk        system clock
//     n_reset    asynchronous active-low reset
//     ioctl      download bus (slave side), see ascii_loader_if
//     baud_sel   0 = BAUD_FAST, 1 = BAUD_SLOW, sampled when a byte starts
//     txd        serial output, idle high
//     busy       FIFO non-empty or transmitter not idle
//     overflow   sticky: a byte was dropped on a full FIFO
//     fsm_state  current transmitter state, for observation
module ascii_loader #(
    parameter int CLK_HZ         = 50000000,
    parameter int DEPTH_LOG2     = 9,
    parameter int BAUD_FAST      = 9600,
    parameter int BAUD_SLOW      = 300,
    parameter int LINE_DELAY_CYC = 5000000,
    parameter int STRIP_LF       = 1
) (
    input  logic                clk,
    input  logic                n_reset,
    ascii_loader_if.slave       ioctl,
    input  logic                baud_sel,
    output logic                txd,
    output logic                busy,
    output logic                overflow,
    output logic [2:0]          fsm_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Rounded divisors, fixed at elaboration.
    localparam logic [31:0] DIV_FAST = 32'((CLK_HZ + BAUD_FAST / 2) / BAUD_FAST);
    localparam logic [31:0] DIV_SLOW = 32'((CLK_HZ + BAUD_SLOW / 2) / BAUD_SLOW);
    localparam logic [31:0] GAP_LAST = (LINE_DELAY_CYC > 0) ? 32'(LINE_DELAY_CYC - 1) : 32'd0;

    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   WAIT_CNT = FULL_CNT - {CNT_ONE[DEPTH_LOG2-1:0], 1'b0};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  download_q;
    logic                  wait_q;

    logic [7:0]            wr_byte;
    logic                  is_lf;
    logic                  wr_req;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  do_write;
    logic                  do_pop;
    logic                  drop;

    logic [2:0]            state;
    logic [7:0]            data_q;
    logic [2:0]            bit_idx;
    logic [31:0]           timer;
    logic [31:0]           div_q;
    logic                  bit_done;
    logic                  frame_end;
    logic                  go_gap;
    logic                  gap_end;

    // Write-side byte filtering and optional case map.
    always_comb begin
        wr_byte = ioctl.ioctl_data;
`ifdef ASCII_UPCASE_EN
        if (ioctl.ioctl_data >= 8'h61 && ioctl.ioctl_data <= 8'h7A)
            wr_byte = ioctl.ioctl_data & 8'hDF;
`else
        wr_byte = ioctl.ioctl_data;
`endif
    end

    assign is_lf      = (STRIP_LF != 0) && (ioctl.ioctl_data == 8'h0A);
    assign wr_req     = ioctl.ioctl_wr && ioctl.ioctl_download && !is_lf;
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    assign bit_done  = (timer == div_q - 32'd1);
    assign frame_end = (state == S_STOP) && bit_done;
    assign go_gap    = frame_end && (data_q == 8'h0D) && (LINE_DELAY_CYC > 0);
    assign gap_end   = (state == S_GAP) && (timer == GAP_LAST);

    // Pop straight out of STOP/GAP as well as IDLE so consecutive frames
    // abut with no idle cycle between them.
    assign do_pop   = !fifo_empty &&
                      ((state == S_IDLE) || (frame_end && !go_gap) || gap_end);
    // A pop in the same cycle frees the slot, so a write at full still lands.
    assign do_write = wr_req && (!fifo_full || do_pop);
    assign drop     = wr_req && fifo_full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= wr_byte;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            download_q <= 1'b0;
            wait_q     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            download_q <= ioctl.ioctl_download;
            // Registered from the current count; the two-entry margin
            // covers this lag plus the producer's reaction cycle.
            wait_q     <= (count >= WAIT_CNT);
            if (do_write)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_write, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (ioctl.ioctl_download && !download_q)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= S_IDLE;
            txd     <= 1'b1;
            data_q  <= 8'h00;
            bit_idx <= 3'd0;
            timer   <= 32'd0;
            div_q   <= DIV_FAST;
        end else if (do_pop) begin
            data_q <= mem[rd_ptr];
            div_q  <= baud_sel ? DIV_SLOW : DIV_FAST;
            timer  <= 32'd0;
            txd    <= 1'b0;
            state  <= S_START;
        end else begin
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                end
                S_START: begin
                    if (bit_done) begin
                        timer   <= 32'd0;
                        bit_idx <= 3'd0;
                        txd     <= data_q[0];
                        state   <= S_DATA;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        timer <= 32'd0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= data_q[bit_idx + 3'd1];
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        timer <= 32'd0;
                        state <= go_gap ? S_GAP : S_IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        timer <= 32'd0;
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy             = !fifo_empty || (state != S_IDLE);
    assign ioctl.ioctl_wait = wait_q;
    assign fsm_state        = state;

endmodule

// File: tb/tb_ascii_loader.sv
// tb_ascii_loader
//   Directed bench for ascii_loader with a small configuration:
//   CLK_HZ=1000, BAUD_FAST=100 (DIV 10), BAUD_SLOW=60 (DIV 17, rounded),
//   LINE_DELAY_CYC=30, DEPTH_LOG2=2 (4 entries, wait at count >= 2).
module tb_ascii_loader;

    localparam int DIV_F = 10;
    localparam int DIV_S = 17;
    localparam int GAP   = 30;

`ifdef ASCII_UPCASE_EN
    localparam logic [7:0] EXP_61 = 8'h41;
    localparam logic [7:0] EXP_7A = 8'h5A;
`else
    localparam logic [7:0] EXP_61 = 8'h61;
    localparam logic [7:0] EXP_7A = 8'h7A;
`endif

    logic       clk      = 1'b0;
    logic       n_reset  = 1'b0;
    logic       baud_sel = 1'b0;
    logic       txd;
    logic       busy;
    logic       overflow;
    logic [2:0] fsm_state;

    ascii_loader_if bus ();

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_wr     = 0;

    logic [7:0] rb;
    logic       sb;
    int         t1;
    int         t2;
    int         tw;
    int         lows;

    ascii_loader #(
        .CLK_HZ         (1000),
        .DEPTH_LOG2     (2),
        .BAUD_FAST      (100),
        .BAUD_SLOW      (60),
        .LINE_DELAY_CYC (GAP),
        .STRIP_LF       (1)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .ioctl     (bus),
        .baud_sel  (baud_sel),
        .txd       (txd),
        .busy      (busy),
        .overflow  (overflow),
        .fsm_state (fsm_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver: one-cycle write strobe; t_wr is the cycle it was presented.
    task automatic write_byte(input logic [7:0] b);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_data = b;
        t_wr           = cyc;
        tick(1);
        bus.ioctl_wr   = 1'b0;
    endtask

    // Receiver: waits for a start bit, samples mid-bit, returns at mid-stop.
    // t_fall is the cycle of the start-bit edge when called before or
    // during the first cycle of the start bit.
    task automatic recv(input int div, output logic [7:0] b, output logic stop_bit,
                        output int t_fall);
        int n;
        n        = 0;
        b        = 8'h00;
        stop_bit = 1'b0;
        while (txd !== 1'b0 && n < 600) begin
            tick(1);
            n++;
        end
        t_fall = cyc;
        chk("rx_start", 32'(txd), 32'd0);
        if (txd === 1'b0) begin
            tick(div / 2);
            for (int i = 0; i < 8; i++) begin
                tick(div);
                b[i] = txd;
            end
            tick(div);
            stop_bit = txd;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_data     = 8'h00;
        tick(3);

        // Reset state
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        n_reset            = 1'b1;
        bus.ioctl_download = 1'b1;
        tick(2);

        // Single byte 0x41: latency, bits, frame length to busy drop
        write_byte(8'h41);
        tw = t_wr;
        chk("wr_busy", 32'(busy), 32'd1);
        recv(DIV_F, rb, sb, t1);
        chk("latency", 32'(t1 - tw), 32'd2);
        chk("byte_41", 32'(rb), 32'h41);
        chk("stop_41", 32'(sb), 32'd1);
        wait_idle("idle_41");
        chk("frame_len", 32'(cyc - t1), 32'(10 * DIV_F));
        chk("idle_txd", 32'(txd), 32'd1);

        // CR, LF, 'B': LF stripped, line gap after CR
        write_byte(8'h0D);
        recv(DIV_F, rb, sb, t1);
        chk("byte_0d", 32'(rb), 32'h0D);
        write_byte(8'h0A);
        write_byte(8'h42);
        recv(DIV_F, rb, sb, t2);
        chk("byte_after_lf", 32'(rb), 32'h42);
        chk("cr_gap", 32'(t2 - t1), 32'(10 * DIV_F + GAP));
        wait_idle("idle_cr");

        // Back-to-back frames abut
        write_byte(8'h55);
        recv(DIV_F, rb, sb, t1);
        write_byte(8'h33);
        recv(DIV_F, rb, sb, t2);
        chk("byte_33", 32'(rb), 32'h33);
        chk("b2b_spacing", 32'(t2 - t1), 32'(10 * DIV_F));
        wait_idle("idle_b2b");

        // baud_sel changed during a byte takes effect on the next one
        write_byte(8'h5A);
        tick(1);
        baud_sel = 1'b1;
        recv(DIV_F, rb, sb, t1);
        chk("byte_5a", 32'(rb), 32'h5A);
        write_byte(8'h3C);
        recv(DIV_S, rb, sb, t2);
        chk("byte_3c_slow", 32'(rb), 32'h3C);
        chk("fast_frame", 32'(t2 - t1), 32'(10 * DIV_F));
        wait_idle("idle_slow");
        chk("slow_frame", 32'(cyc - t2), 32'(10 * DIV_S));
        baud_sel = 1'b0;

        // Fill past full: wait, overflow, drain after download ends
        write_byte(8'h31);
        write_byte(8'h32);
        write_byte(8'h33);
        chk("wait_lo", 32'(bus.ioctl_wait), 32'd0);
        write_byte(8'h34);
        chk("wait_hi", 32'(bus.ioctl_wait), 32'd1);
        write_byte(8'h35);
        chk("ovf_before_full", 32'(overflow), 32'd0);
        write_byte(8'h36);
        chk("ovf_set", 32'(overflow), 32'd1);
        bus.ioctl_download = 1'b0;
        for (int i = 0; i < 5; i++) begin
            recv(DIV_F, rb, sb, t1);
            chk($sformatf("drain_%0d", i), 32'(rb), 32'(8'h31 + i));
        end
        wait_idle("idle_drain");
        chk("wait_drained", 32'(bus.ioctl_wait), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        bus.ioctl_download = 1'b1;
        tick(1);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Strobes outside a download are ignored
        bus.ioctl_download = 1'b0;
        write_byte(8'h77);
        tick(2);
        chk("no_download", 32'(busy), 32'd0);
        bus.ioctl_download = 1'b1;
        tick(1);

        // Reset during DATA bit 3 of 0x96 (bit3 = 0), with a byte queued
        write_byte(8'h96);
        tick(1);
        t1 = cyc;
        write_byte(8'h69);
        tick(3 * DIV_F + DIV_F + 5 - (cyc - t1) - 1);
        chk("pre_rst_state", 32'(fsm_state), 32'd2);
        chk("pre_rst_txd", 32'(txd), 32'd0);
        n_reset = 1'b0;
        #1;
        chk("async_txd", 32'(txd), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_state", 32'(fsm_state), 32'd0);
        tick(2);
        n_reset = 1'b1;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (txd !== 1'b1) lows++;
        end
        chk("post_rst_quiet", 32'(lows), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Case map (build-dependent) and bytes just outside a-z
        write_byte(8'h61);
        recv(DIV_F, rb, sb, t1);
        chk("case_61", 32'(rb), 32'(EXP_61));
        write_byte(8'h7B);
        recv(DIV_F, rb, sb, t1);
        chk("case_7b", 32'(rb), 32'h7B);
        write_byte(8'h7A);
        recv(DIV_F, rb, sb, t1);
        chk("case_7a", 32'(rb), 32'(EXP_7A));
        write_byte(8'h60);
        recv(DIV_F, rb, sb, t1);
        chk("case_60", 32'(rb), 32'h60);
        chk("case_stop", 32'(sb), 32'd1);
        wait_idle("idle_case");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
